conv_kernel_sequencer: RTL and testbench

//   Sequences one row-parallel bank of conv_3 units over a full image for NUM_KERNELS kernels, one kernel after another.
//   For each kernel it fetches the kernel rows from kernel memory and streams them with kernel_load.
//   It then streams every image column from image memory and drives valid_in and valid_out.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_tag_delay.sv | 54 +++++
 rtl/conv_kernel_sequencer.sv | 171 +++++++++++++++++
 tb/tb_conv_kernel_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the conv bank sequencer.
// The *_W localparams give the widths for the default 3x3 / 12-column / 2-kernel configuration.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        IMG,
        DRAIN,
        FIN
    } seq_state_t;

    // Address/index width for n distinct values; never narrower than one bit.
    function automatic int w_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int COL_W   = w_of(12);
    localparam int KIDX_W  = w_of(2);
    localparam int KADDR_W = w_of(2 * 3);

endpackage

// File: rtl/conv_tag_delay.sv
// Delay line that carries result tags alongside the conv bank's pipeline.
// Tags are zero whenever their valid bit is clear.
module conv_tag_delay #(
    parameter int LAT    = 1,
    parameter int COL_W  = 4,
    parameter int KIDX_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [COL_W-1:0]  in_col,
    input  logic [KIDX_W-1:0] in_kidx,
    output logic              out_vld,
    output logic [COL_W-1:0]  out_col,
    output logic [KIDX_W-1:0] out_kidx,
    output logic              empty
);

    logic [LAT-1:0]             vld_pipe_q, vld_pipe_d;
    logic [LAT-1:0][COL_W-1:0]  col_pipe_q, col_pipe_d;
    logic [LAT-1:0][KIDX_W-1:0] kidx_pipe_q, kidx_pipe_d;

    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        col_pipe_d     = col_pipe_q;
        kidx_pipe_d    = kidx_pipe_q;
        vld_pipe_d[0]  = in_vld;
        col_pipe_d[0]  = in_col;
        kidx_pipe_d[0] = in_kidx;
        for (int i = 1; i < LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            col_pipe_d[i]  = col_pipe_q[i-1];
            kidx_pipe_d[i] = kidx_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            col_pipe_q  <= '0;
            kidx_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            col_pipe_q  <= col_pipe_d;
            kidx_pipe_q <= kidx_pipe_d;
        end
    end

    assign out_vld  = vld_pipe_q[LAT-1];
    assign out_col  = col_pipe_q[LAT-1];
    assign out_kidx = kidx_pipe_q[LAT-1];
    assign empty    = ~|vld_pipe_q;

endmodule

// File: rtl/conv_kernel_sequencer.sv
// Walks one row-parallel conv bank through every kernel: kernel rows first, then all image columns,
// and tags each completed window with its column and kernel index.
module conv_kernel_sequencer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 12,
    parameter int NUM_KERNELS = 2,
    parameter int CONV_LAT    = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          pause,
    output logic                                          k_rd_en,
    output logic [w_of(NUM_KERNELS*KERNEL_SIZE)-1:0]      k_rd_addr,
    output logic                                          img_rd_en,
    output logic [w_of(IMAGE_SIZE)-1:0]                   img_rd_col,
    output logic                                          kernel_load,
    output logic                                          valid_in,
    output logic                                          valid_out,
    output logic                                          out_valid,
    output logic [w_of(IMAGE_SIZE)-1:0]                   out_col,
    output logic [w_of(NUM_KERNELS)-1:0]                  out_kernel,
    output logic                                          busy,
    output logic                                          done
);

    localparam int CW     = w_of(IMAGE_SIZE);
    localparam int KW     = w_of(NUM_KERNELS);
    localparam int AW     = w_of(NUM_KERNELS * KERNEL_SIZE);
    // Counters carry one spare bit so the terminal compares cannot wrap.
    localparam int ROW_W  = $clog2(KERNEL_SIZE) + 1;
    localparam int CC_W   = $clog2(IMAGE_SIZE) + 1;
    localparam int KC_W   = $clog2(NUM_KERNELS) + 1;

    if (DATA_WIDTH < 1 || KERNEL_SIZE < 2 || IMAGE_SIZE < KERNEL_SIZE ||
        NUM_KERNELS < 1 || CONV_LAT < 1) begin : g_param_check
        $error("conv_kernel_sequencer: illegal parameter combination");
    end

    seq_state_t        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CC_W-1:0]   col_q, col_d;
    logic [KC_W-1:0]   kidx_q, kidx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              kernel_load_q, kernel_load_d;
    logic              valid_in_q, valid_in_d;
    logic              valid_out_q, valid_out_d;
    logic [CW-1:0]     col_tag_q, col_tag_d;
    logic [KW-1:0]     kidx_tag_q, kidx_tag_d;
    logic [CC_W-1:0]   col_off;
    logic              pipe_empty;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        kidx_d    = kidx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        k_rd_en   = 1'b0;
        img_rd_en = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = KLOAD;
                row_d   = '0;
                col_d   = '0;
                kidx_d  = '0;
                busy_d  = 1'b1;
            end
            KLOAD: if (!pause) begin
                k_rd_en = 1'b1;
                if (row_q == ROW_W'(KERNEL_SIZE - 1)) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = IMG;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            IMG: if (!pause) begin
                img_rd_en = 1'b1;
                if (col_q == CC_W'(IMAGE_SIZE - 1)) begin
                    col_d = '0;
                    if (kidx_q < KC_W'(NUM_KERNELS - 1)) begin
                        kidx_d  = kidx_q + 1'b1;
                        state_d = KLOAD;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            // The presentation register and the delay line must both be empty before done.
            DRAIN: if (pipe_empty && !valid_out_q) begin
                state_d = FIN;
                done_d  = 1'b1;
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Flags and tags as seen by the bank one cycle later, when the memory word arrives.
        col_off       = col_q - CC_W'(KERNEL_SIZE - 1);
        kernel_load_d = k_rd_en;
        valid_in_d    = k_rd_en | img_rd_en;
        valid_out_d   = img_rd_en && (col_q >= CC_W'(KERNEL_SIZE - 1));
        col_tag_d     = valid_out_d ? col_off[CW-1:0] : '0;
        kidx_tag_d    = valid_out_d ? kidx_q[KW-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            kidx_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            kernel_load_q <= 1'b0;
            valid_in_q    <= 1'b0;
            valid_out_q   <= 1'b0;
            col_tag_q     <= '0;
            kidx_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            kidx_q        <= kidx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            kernel_load_q <= kernel_load_d;
            valid_in_q    <= valid_in_d;
            valid_out_q   <= valid_out_d;
            col_tag_q     <= col_tag_d;
            kidx_tag_q    <= kidx_tag_d;
        end
    end

    conv_tag_delay #(
        .LAT    (CONV_LAT),
        .COL_W  (CW),
        .KIDX_W (KW)
    ) u_tag_delay (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (valid_out_q),
        .in_col   (col_tag_q),
        .in_kidx  (kidx_tag_q),
        .out_vld  (out_valid),
        .out_col  (out_col),
        .out_kidx (out_kernel),
        .empty    (pipe_empty)
    );

    assign k_rd_addr   = AW'(kidx_q) * AW'(KERNEL_SIZE) + AW'(row_q);
    assign img_rd_col  = col_q[CW-1:0];
    assign kernel_load = kernel_load_q;
    assign valid_in    = valid_in_q;
    assign valid_out   = valid_out_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv_kernel_sequencer.sv
// Scoreboard bench: three sequencer instances (default, 3-column single kernel, CONV_LAT=4),
// exercised one at a time; a negedge monitor pops expected reads and results.
module tb_conv_kernel_sequencer;
    import conv_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v, pause_v;
    logic [2:0] k_rd_en_v, img_rd_en_v, kernel_load_v, valid_in_v, valid_out_v;
    logic [2:0] out_valid_v, busy_v, done_v;
    logic [7:0] kaddr_v [3];
    logic [7:0] icol_v  [3];
    logic [7:0] ocol_v  [3];
    logic [7:0] okern_v [3];

    int checks = 0;
    int errors = 0;
    int q_rd [$];
    int q_out [$];
    bit [2:0] prev_k, prev_i;
    int prev_col [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int IS  = (g == 1) ? 3 : 12;
        localparam int NK  = (g == 1) ? 1 : 2;
        localparam int LAT = (g == 2) ? 4 : 1;
        logic [w_of(NK*3)-1:0] kaddr;
        logic [w_of(IS)-1:0]   icol, ocol;
        logic [w_of(NK)-1:0]   okern;

        conv_kernel_sequencer #(
            .DATA_WIDTH (16), .KERNEL_SIZE (3), .IMAGE_SIZE (IS),
            .NUM_KERNELS (NK), .CONV_LAT (LAT)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_v[g]),
            .pause       (pause_v[g]),
            .k_rd_en     (k_rd_en_v[g]),
            .k_rd_addr   (kaddr),
            .img_rd_en   (img_rd_en_v[g]),
            .img_rd_col  (icol),
            .kernel_load (kernel_load_v[g]),
            .valid_in    (valid_in_v[g]),
            .valid_out   (valid_out_v[g]),
            .out_valid   (out_valid_v[g]),
            .out_col     (ocol),
            .out_kernel  (okern),
            .busy        (busy_v[g]),
            .done        (done_v[g])
        );

        assign kaddr_v[g] = 8'(kaddr);
        assign icol_v[g]  = 8'(icol);
        assign ocol_v[g]  = 8'(ocol);
        assign okern_v[g] = 8'(okern);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int outs_or(input int d);
        return int'({k_rd_en_v[d], img_rd_en_v[d], kernel_load_v[d], valid_in_v[d],
                     valid_out_v[d], out_valid_v[d], busy_v[d], done_v[d]})
             | kaddr_v[d] | icol_v[d] | ocol_v[d] | okern_v[d];
    endfunction

    // Expected read order and result tags for a full run of instance d (K=3 everywhere).
    task automatic push_exp(input int d);
        int nk = (d == 1) ? 1 : 2;
        int is = (d == 1) ? 3 : 12;
        for (int k = 0; k < nk; k++) begin
            for (int r = 0; r < 3; r++) q_rd.push_back((1 << 16) | (k * 3 + r));
            for (int c = 0; c < is; c++) q_rd.push_back((2 << 16) | c);
            for (int c = 0; c <= is - 3; c++) q_out.push_back((k << 8) | c);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_k <= '0;
            prev_i <= '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (k_rd_en_v[d]) begin
                    if (q_rd.size() == 0) chk("RD_EXTRA", kaddr_v[d], -1);
                    else chk("RD_SEQ", (1 << 16) | kaddr_v[d], q_rd.pop_front());
                end
                if (img_rd_en_v[d]) begin
                    if (q_rd.size() == 0) chk("RD_EXTRA", icol_v[d], -1);
                    else chk("RD_SEQ", (2 << 16) | icol_v[d], q_rd.pop_front());
                end
                if (out_valid_v[d]) begin
                    if (q_out.size() == 0) chk("OUT_EXTRA", ocol_v[d], -1);
                    else chk("OUT_TAG", (okern_v[d] << 8) | ocol_v[d], q_out.pop_front());
                end
                if (kernel_load_v[d] | valid_in_v[d] | valid_out_v[d] | prev_k[d] | prev_i[d])
                    chk("FLAGS", {kernel_load_v[d], valid_in_v[d], valid_out_v[d]},
                        {prev_k[d], prev_k[d] | prev_i[d], prev_i[d] && prev_col[d] >= 2});
                if (pause_v[d] && busy_v[d])
                    chk("PAUSE_NO_RD", k_rd_en_v[d] | img_rd_en_v[d], 0);
                prev_k[d]   <= k_rd_en_v[d];
                prev_i[d]   <= img_rd_en_v[d];
                prev_col[d] <= icol_v[d];
            end
        end
    end

    // One full run on instance d; optional 5-cycle pause at the first sight of column pause_col.
    task automatic run(input int d, input int pause_col, input bit hold_start, input int exp_done);
        bit got = 0;
        bit paused = 0;
        int pl = 0;
        push_exp(d);
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        chk("BUSY_ON", busy_v[d], 1);
        if (!hold_start) start_v[d] = 1'b0;
        for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
            @(posedge clk); #1;
            if (pl > 0) begin
                pl--;
                if (pl == 0) pause_v[d] = 1'b0;
            end
            if (done_v[d]) begin
                got = 1;
                chk("DONE_LAT", cyc, exp_done);
            end else if (pause_col >= 0 && !paused && img_rd_en_v[d] && icol_v[d] == 8'(pause_col)) begin
                pause_v[d] = 1'b1;
                pl = 5;
                paused = 1;
            end
        end
        if (!got) chk("DONE_TIMEOUT", 0, 1);
        start_v[d] = 1'b0;
        @(posedge clk); #1;
        chk("DONE_PULSE", {done_v[d], busy_v[d]}, 0);
        chk("RD_LEFT", q_rd.size(), 0);
        chk("OUT_LEFT", q_out.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL WATCHDOG no completion");
        $fatal(1);
    end

    initial begin
        bit found = 0;
        bit seen_k3 = 0;
        int nodone = 0;
        rst = 1'b1;
        start_v = '0;
        pause_v = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("RESET_STATE", outs_or(d), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full default run, then the same with a 5-cycle pause at column 6.
        run(0, -1, 0, 33);
        run(0, 6, 0, 38);

        // Abort at kernel 1, column 4.
        push_exp(0);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            if (k_rd_en_v[0] && kaddr_v[0] == 8'd3) seen_k3 = 1;
            if (seen_k3 && img_rd_en_v[0] && icol_v[0] == 8'd4) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("RST_POINT", found, 1);
        rst = 1'b1;
        #1;
        chk("RST_CLEAR", outs_or(0), 0);
        q_rd.delete();
        q_out.delete();
        repeat (3) begin
            @(posedge clk); #1;
            nodone |= done_v[0] | busy_v[0];
        end
        chk("RST_NO_DONE", nodone, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run(0, -1, 0, 33);

        // Single-window image with start held through FIN.
        run(1, -1, 1, 9);
        nodone = 0;
        repeat (4) begin
            @(posedge clk); #1;
            nodone |= busy_v[1] | done_v[1] | k_rd_en_v[1];
        end
        chk("NO_RETRIGGER", nodone, 0);

        // Deeper bank latency.
        run(2, -1, 0, 36);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
